// File: rtl/cpu32_pkg.sv
// Shared widths, register-index types and small helpers for the 32-bit register file.
package cpu32_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // A read port sees the write data in the same cycle only for a real (non-x0) register.
    function automatic logic bypass_hit(logic we, reg_addr_t wa, reg_addr_t ra);
        return we && (wa == ra) && (wa != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile32_if.sv
// Write/read bus of the register file; the master issues requests, the slave returns read data.
interface regfile32_if;
    import cpu32_pkg::*;

    logic      WE;
    reg_addr_t WA;
    word_t     WD;
    logic      RE;
    reg_addr_t RA1;
    reg_addr_t RA2;
    word_t     RD1;
    word_t     RD2;
    logic      RVALID;

    modport master (
        output WE, WA, WD, RE, RA1, RA2,
        input  RD1, RD2, RVALID
    );

    modport slave (
        input  WE, WA, WD, RE, RA1, RA2,
        output RD1, RD2, RVALID
    );

endinterface

// File: rtl/regfile32_word.sv
// One architectural register: loads on enable, cleared asynchronously by reset.
module regfile_word
    import cpu32_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  load,
    input  word_t d,
    output word_t q
);

    // Hold the stored word; capture d only when this register is addressed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile32.sv
// 31 writable registers plus hard-wired x0, two registered read ports with
// write-to-read bypass so a same-edge read returns the value being written.
module regfile32
    import cpu32_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    regfile32_if.slave bus
);

    word_t             words [NREG];
    logic [NREG-1:1]   load;
    word_t             rd1_next;
    word_t             rd2_next;
    word_t             rd1_q;
    word_t             rd2_q;
    logic              rvalid_q;

    // x0 has no storage; the entry exists only so the read mux can be indexed uniformly.
    assign words[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_word
        assign load[i] = bus.WE && (bus.WA == reg_addr_t'(i));

        regfile_word u_word (
            .CLK   (CLK),
            .RST_N (RST_N),
            .load  (load[i]),
            .d     (bus.WD),
            .q     (words[i])
        );
    end

    // Select read data: x0 reads zero, a same-edge write wins over the stored word.
    always_comb begin
        rd1_next = words[bus.RA1];
        rd2_next = words[bus.RA2];
        if (bus.RA1 == ZERO_REG) begin
            rd1_next = '0;
        end else if (bypass_hit(bus.WE, bus.WA, bus.RA1)) begin
            rd1_next = bus.WD;
        end
        if (bus.RA2 == ZERO_REG) begin
            rd2_next = '0;
        end else if (bypass_hit(bus.WE, bus.WA, bus.RA2)) begin
            rd2_next = bus.WD;
        end
    end

    // Output registers: update only on a read request, otherwise hold; RVALID follows RE by one edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd1_q    <= '0;
            rd2_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.RE;
            if (bus.RE) begin
                rd1_q <= rd1_next;
                rd2_q <= rd2_next;
            end
        end
    end

    assign bus.RD1    = rd1_q;
    assign bus.RD2    = rd2_q;
    assign bus.RVALID = rvalid_q;

endmodule

// File: tb/tb_regfile32.sv
// Scoreboard bench for regfile32: stimulus pushes hand-computed read results,
// a monitor pops and compares whenever RVALID is presented.
module tb_regfile32;

    logic CLK;
    logic RST_N;

    regfile32_if bus();

    regfile32 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus; a read request queues its expected (RD1, RD2).
    task automatic issue(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [31:0] e1, input logic [31:0] e2);
        @(negedge CLK);
        bus.WE  = we;
        bus.WA  = wa;
        bus.WD  = wd;
        bus.RE  = re;
        bus.RA1 = ra1;
        bus.RA2 = ra2;
        if (re) exp_q.push_back({e1, e2});
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    // Monitor: compare every presented read result against the scoreboard.
    always @(posedge CLK) begin
        #1;
        if (bus.RVALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got RVALID=1, expected no pending read");
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd1", bus.RD1, mon_exp[63:32]);
                check("rd2", bus.RD2, mon_exp[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N   = 1'b1;
        bus.WE  = 1'b0;
        bus.WA  = '0;
        bus.WD  = '0;
        bus.RE  = 1'b0;
        bus.RA1 = '0;
        bus.RA2 = '0;
        #1 RST_N = 1'b0;
        #1;
        check("reset_rd1", bus.RD1, 32'h0);
        check("reset_rd2", bus.RD2, 32'h0);
        check("reset_rvalid", {31'b0, bus.RVALID}, 32'h0);
        #10 RST_N = 1'b1;

        // Populate x5, read it back so RD1 is nonzero before a mid-cycle reset.
        issue(1'b1, 5'd5, 32'h5555_AAAA, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'h5555_AAAA, 32'h0);
        idle();

        // Mid-cycle reset clears outputs immediately; WE/RE ignored while held.
        #2 RST_N = 1'b0;
        #1;
        check("midrst_rd1", bus.RD1, 32'h0);
        check("midrst_rd2", bus.RD2, 32'h0);
        check("midrst_rvalid", {31'b0, bus.RVALID}, 32'h0);
        bus.WE  = 1'b1;
        bus.WA  = 5'd5;
        bus.WD  = 32'h0000_0001;
        bus.RE  = 1'b1;
        bus.RA1 = 5'd5;
        @(posedge CLK);
        #1;
        check("inrst_rvalid", {31'b0, bus.RVALID}, 32'h0);
        check("inrst_rd1", bus.RD1, 32'h0);
        @(negedge CLK);
        bus.WE = 1'b0;
        bus.RE = 1'b0;
        #2 RST_N = 1'b1;
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 32'h0, 32'h0);

        // Write then later read, with x0 on the second port.
        issue(1'b1, 5'd3, 32'hA5A5_F00D, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        idle();
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 32'hA5A5_F00D, 32'h0);

        // RE=0: outputs hold while x3 is overwritten, RVALID drops.
        issue(1'b1, 5'd3, 32'h0BAD_CAFE, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        @(posedge CLK);
        #1;
        check("hold_rd1", bus.RD1, 32'hA5A5_F00D);
        check("hold_rvalid", {31'b0, bus.RVALID}, 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // x0 writes have no effect; x0 reads zero even with a same-edge x0 write.
        issue(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 32'h0, 32'h0BAD_CAFE);
        issue(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0);

        // Bypass on both ports and on a single port.
        issue(1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h1111_1111, 32'h1111_1111);
        issue(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3, 32'h1234_5678, 32'h0BAD_CAFE);
        issue(1'b1, 5'd3, 32'hCAFE_0003, 1'b1, 5'd7, 5'd3, 32'h1234_5678, 32'hCAFE_0003);

        // Edge addresses and persistence of untouched words.
        issue(1'b1, 5'd1, 32'h0000_0001, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        issue(1'b1, 5'd31, 32'hFFFF_0031, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd31, 32'h0000_0001, 32'hFFFF_0031);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd2, 32'h1234_5678, 32'h0);
        idle();

        // Reset held across an edge with a pending write to x9 discards it.
        bus.WE = 1'b1;
        bus.WA = 5'd9;
        bus.WD = 32'hFFFF_FFFF;
        #2 RST_N = 1'b0;
        @(negedge CLK);
        bus.WE = 1'b0;
        #2 RST_N = 1'b1;
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3, 32'h0, 32'h0);
        issue(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 32'h9999_0009, 32'h0);
        idle();

        repeat (3) @(negedge CLK);
        check("pending_reads", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
